// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ALU op codes and the issue bundle.
// Imported by the decode sub-module and the issue stage.
package riscv_pkg;

    localparam int REG_W  = 32;
    localparam int CODE_W = 7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [CODE_W-1:0] ALU_ADD   = 7'd0;
    localparam logic [CODE_W-1:0] ALU_SUB   = 7'd1;
    localparam logic [CODE_W-1:0] ALU_AND   = 7'd2;
    localparam logic [CODE_W-1:0] ALU_OR    = 7'd3;
    localparam logic [CODE_W-1:0] ALU_XOR   = 7'd4;
    localparam logic [CODE_W-1:0] ALU_SLT   = 7'd5;
    localparam logic [CODE_W-1:0] ALU_SLL   = 7'd6;
    localparam logic [CODE_W-1:0] ALU_SLTU  = 7'd7;
    localparam logic [CODE_W-1:0] ALU_SRL   = 7'd8;
    localparam logic [CODE_W-1:0] ALU_SRA   = 7'd9;
    localparam logic [CODE_W-1:0] ALU_BEQ   = 7'd10;
    localparam logic [CODE_W-1:0] ALU_BNE   = 7'd11;
    localparam logic [CODE_W-1:0] ALU_BLT   = 7'd12;
    localparam logic [CODE_W-1:0] ALU_BGE   = 7'd13;
    localparam logic [CODE_W-1:0] ALU_BLTU  = 7'd14;
    localparam logic [CODE_W-1:0] ALU_BGEU  = 7'd15;
    localparam logic [CODE_W-1:0] ALU_PASSB = 7'd16;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U
    } imm_t;

    typedef enum logic [1:0] {
        A_ZERO,
        A_RS1,
        A_PC
    } asel_t;

    typedef struct packed {
        logic [CODE_W-1:0] alu_control;
        logic [REG_W-1:0]  src_a;
        logic [REG_W-1:0]  src_b;
        logic [REG_W-1:0]  imm;
        logic [REG_W-1:0]  pc;
        logic [4:0]        rd;
        logic              reg_write;
        logic              is_branch;
        logic              illegal;
    } issue_t;

    function automatic logic [REG_W-1:0] imm_gen(
        input logic [31:0] instr,
        input imm_t        sel
    );
        logic [REG_W-1:0] imm;
        imm = '0;
        unique case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode: instruction, PC and register data
// into one issue bundle for the ALU.
module alu_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [31:0]      instr,
    input  logic [REG_W-1:0] pc,
    input  logic [REG_W-1:0] rs1_data,
    input  logic [REG_W-1:0] rs2_data,
    output issue_t           bundle
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [CODE_W-1:0] code;
    imm_t              imm_sel;
    asel_t             a_sel;
    logic              b_imm;
    logic              rw;
    logic              br;
    logic              ill;
    logic [REG_W-1:0]  imm;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm    = imm_gen(instr, imm_sel);

    always_comb begin
        code    = ALU_ADD;
        imm_sel = IMM_NONE;
        a_sel   = A_ZERO;
        b_imm   = 1'b0;
        rw      = 1'b0;
        br      = 1'b0;
        ill     = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                a_sel = A_RS1;
                rw    = 1'b1;
                if (f7 == F7_BASE) begin
                    unique case (f3)
                        F3_ADD:  code = ALU_ADD;
                        F3_SLL:  code = ALU_SLL;
                        F3_SLT:  code = ALU_SLT;
                        F3_SLTU: code = ALU_SLTU;
                        F3_XOR:  code = ALU_XOR;
                        F3_SR:   code = ALU_SRL;
                        F3_OR:   code = ALU_OR;
                        F3_AND:  code = ALU_AND;
                        default: ill  = 1'b1;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    code = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    code = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                a_sel   = A_RS1;
                imm_sel = IMM_I;
                b_imm   = 1'b1;
                rw      = 1'b1;
                unique case (f3)
                    F3_ADD:  code = ALU_ADD;
                    F3_SLT:  code = ALU_SLT;
                    F3_SLTU: code = ALU_SLTU;
                    F3_XOR:  code = ALU_XOR;
                    F3_OR:   code = ALU_OR;
                    F3_AND:  code = ALU_AND;
                    F3_SLL: begin
                        code = ALU_SLL;
                        ill  = (f7 != F7_BASE);
                    end
                    F3_SR: begin
                        if (f7 == F7_BASE) code = ALU_SRL;
                        else if (f7 == F7_ALT) code = ALU_SRA;
                        else ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                code    = ALU_PASSB;
                imm_sel = IMM_U;
                b_imm   = 1'b1;
                rw      = 1'b1;
            end
            OPC_AUIPC: begin
                a_sel   = A_PC;
                imm_sel = IMM_U;
                b_imm   = 1'b1;
                rw      = 1'b1;
            end
            OPC_BRANCH: begin
                a_sel   = A_RS1;
                imm_sel = IMM_B;
                br      = 1'b1;
                unique case (f3)
                    F3_BEQ:  code = ALU_BEQ;
                    F3_BNE:  code = ALU_BNE;
                    F3_BLT:  code = ALU_BLT;
                    F3_BGE:  code = ALU_BGE;
                    F3_BLTU: code = ALU_BLTU;
                    F3_BGEU: code = ALU_BGEU;
                    default: ill  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                a_sel   = A_RS1;
                imm_sel = IMM_I;
                b_imm   = 1'b1;
                rw      = 1'b1;
            end
            OPC_STORE: begin
                a_sel   = A_RS1;
                imm_sel = IMM_S;
                b_imm   = 1'b1;
            end
            default: ill = 1'b1;
        endcase
    end

    // Illegal encodings issue as a harmless zeroed ADD; traps are raised later.
    always_comb begin
        bundle    = '0;
        bundle.pc = pc;
        if (ill) begin
            bundle.illegal = 1'b1;
        end else begin
            bundle.alu_control = code;
            bundle.imm         = imm;
            unique case (a_sel)
                A_RS1:   bundle.src_a = rs1_data;
                A_PC:    bundle.src_a = pc;
                default: bundle.src_a = '0;
            endcase
            bundle.src_b     = b_imm ? imm : rs2_data;
            bundle.rd        = rw ? instr[11:7] : 5'd0;
            bundle.reg_write = rw;
            bundle.is_branch = br;
        end
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Decode/issue stage: registers the decoded ALU bundle and hands it
// to execute through a two-entry valid/ready skid buffer.
module alu_ctrl_issue
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   srcA,
    output logic [XLEN-1:0]   srcB,
    output logic [CTRL_W-1:0] alu_control,
    output logic [CTRL_W-1:0] alu_control_1,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        rd,
    output logic              reg_write,
    output logic              is_branch,
    output logic              illegal
);

    issue_t dec;
    issue_t main_q;
    issue_t main_n;
    issue_t skid_q;
    issue_t skid_n;
    logic   main_v;
    logic   main_v_n;
    logic   skid_v;
    logic   skid_v_n;
    logic   rdy_q;
    logic   in_fire;
    logic   out_fire;

    alu_ctrl_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .bundle   (dec)
    );

    assign in_fire  = in_valid && rdy_q;
    assign out_fire = main_v && out_ready;

    always_comb begin
        main_n   = main_q;
        main_v_n = main_v;
        skid_n   = skid_q;
        skid_v_n = skid_v;
        if (out_fire || !main_v) begin
            if (skid_v) begin
                main_n   = skid_q;
                main_v_n = 1'b1;
                skid_v_n = 1'b0;
            end else if (in_fire) begin
                main_n   = dec;
                main_v_n = 1'b1;
            end else begin
                main_v_n = 1'b0;
            end
        end else if (in_fire) begin
            skid_n   = dec;
            skid_v_n = 1'b1;
        end
    end

    // in_ready is a flop so it never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            main_q <= main_n;
            skid_q <= skid_n;
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            rdy_q  <= !skid_v_n;
        end
    end

    assign in_ready      = rdy_q;
    assign out_valid     = main_v;
    assign srcA          = main_q.src_a;
    assign srcB          = main_q.src_b;
    assign alu_control   = main_q.alu_control;
    assign alu_control_1 = '0;
    assign out_imm       = main_q.imm;
    assign out_pc        = main_q.pc;
    assign rd            = main_q.rd;
    assign reg_write     = main_q.reg_write;
    assign is_branch     = main_q.is_branch;
    assign illegal       = main_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: decode results, skid buffer
// ordering, backpressure and reset flush.
module tb_alu_ctrl_issue;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [6:0]  c1;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [6:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [6:0]  alu_control;
    logic [6:0]  alu_control_1;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t cur;
    exp_t got;
    exp_t sb[$];
    exp_t obs[$];

    always #5 clk = ~clk;

    alu_ctrl_issue #(.XLEN(32), .CTRL_W(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .srcA          (srcA),
        .srcB          (srcB),
        .alu_control   (alu_control),
        .alu_control_1 (alu_control_1),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .rd            (rd),
        .reg_write     (reg_write),
        .is_branch     (is_branch),
        .illegal       (illegal)
    );

    assign got = {alu_control, alu_control_1, srcA, srcB, out_imm,
                  out_pc, rd, reg_write, is_branch, illegal};

    // Collect accepted inputs and issued outputs; comparison is done by the tests.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) obs.push_back(got);
        if (!reset && in_valid && in_ready) sb.push_back(cur);
    end

    function automatic exp_t mk(input logic [6:0] ctrl,
                                input logic [31:0] a, b, imm, pc,
                                input logic [4:0] rdx,
                                input logic rw, br, ill);
        exp_t e;
        e = '{ctrl: ctrl, c1: 7'd0, a: a, b: b, imm: imm, pc: pc,
              rd: rdx, rw: rw, br: br, ill: ill};
        return e;
    endfunction

    task automatic send(input logic [31:0] ins, pc, r1, r2,
                        input exp_t e, output int stalls);
        in_instr = ins;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        cur      = e;
        in_valid = 1'b1;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout instr=%h in_ready=%b required=1", ins, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got=%b required=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready got=%b required=0", in_ready);
        end
        checks++;
        if ({srcA, srcB, alu_control, out_pc, rd, reg_write, illegal} !== '0) begin
            errors++;
            $display("FAIL rst_fields srcA=%h srcB=%h ctrl=%0d required all 0", srcA, srcB, alu_control);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_in_ready got=%b required=1", in_ready);
        end
    endtask

    task automatic test_decode();
        vec_t v[14];
        int   st;
        int   n;
        exp_t e;
        exp_t g;
        v[0]  = '{32'h00500093, 32'd0, 32'd0, 7'd0, 32'd0, 32'd5, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0};
        v[1]  = '{32'h402081B3, 32'd10, 32'd3, 7'd1, 32'd10, 32'd3, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0};
        v[2]  = '{32'h0020F463, 32'd7, 32'd9, 7'd15, 32'd7, 32'd9, 32'd8, 5'd0, 1'b0, 1'b1, 1'b0};
        v[3]  = '{32'h123450B7, 32'hDEADBEEF, 32'h55, 7'd16, 32'd0, 32'h12345000, 32'h12345000, 5'd1, 1'b1, 1'b0, 1'b0};
        v[4]  = '{32'h00000000, 32'd1, 32'd2, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        v[5]  = '{32'h0200C0B3, 32'd1, 32'd2, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        v[6]  = '{32'h00001117, 32'd3, 32'd4, 7'd0, 32'h1018, 32'h1000, 32'h1000, 5'd2, 1'b1, 1'b0, 1'b0};
        v[7]  = '{32'hFFC0A283, 32'h200, 32'd0, 7'd0, 32'h200, 32'hFFFFFFFC, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b0, 1'b0};
        v[8]  = '{32'h0020A423, 32'h300, 32'hAB, 7'd0, 32'h300, 32'd8, 32'd8, 5'd0, 1'b0, 1'b0, 1'b0};
        v[9]  = '{32'h4030D093, 32'h80000000, 32'd0, 7'd9, 32'h80000000, 32'h403, 32'h403, 5'd1, 1'b1, 1'b0, 1'b0};
        v[10] = '{32'h40309093, 32'd1, 32'd2, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        v[11] = '{32'h0020A463, 32'd1, 32'd2, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1};
        v[12] = '{32'hFE209EE3, 32'd5, 32'd6, 7'd11, 32'd5, 32'd6, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b1, 1'b0};
        v[13] = '{32'h0020B233, 32'd1, 32'd2, 7'd7, 32'd1, 32'd2, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            e = mk(v[i].ctrl, v[i].a, v[i].b, v[i].imm, 32'h1000 + 32'(4 * i),
                   v[i].rd, v[i].rw, v[i].br, v[i].ill);
            send(v[i].ins, 32'h1000 + 32'(4 * i), v[i].r1, v[i].r2, e, st);
            checks++;
            if (st !== 0) begin
                errors++;
                $display("FAIL decode_stall idx=%0d stalls=%0d required=0", i, st);
            end
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_valid && n < 50);
        checks++;
        if (obs.size() !== 14 || sb.size() !== 14) begin
            errors++;
            $display("FAIL decode_count issued=%0d accepted=%0d required=14", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            g = obs.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL decode_issue got=%h required=%h", g, e);
            end
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_back_to_back();
        int   st;
        int   n;
        exp_t e;
        exp_t g;
        exp_t e3;
        out_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            e = mk(7'd0, 32'(i), 32'h10, 32'd0, 32'h2000 + 32'(i), 5'd5, 1'b1, 1'b0, 1'b0);
            send(32'h002082B3, 32'h2000 + 32'(i), 32'(i), 32'h10, e, st);
            checks++;
            if (st !== 0) begin
                errors++;
                $display("FAIL skid_accept idx=%0d stalls=%0d required=0", i, st);
            end
        end
        e3 = mk(7'd0, 32'd3, 32'h10, 32'd0, 32'h2003, 5'd5, 1'b1, 1'b0, 1'b0);
        in_instr = 32'h002082B3;
        in_pc    = 32'h2003;
        rs1_data = 32'd3;
        rs2_data = 32'h10;
        cur      = e3;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || srcA !== 32'd1) begin
                errors++;
                $display("FAIL skid_hold cyc=%0d in_ready=%b out_valid=%b srcA=%h required 0 1 1",
                         c, in_ready, out_valid, srcA);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h002082B3, 32'h2003, 32'd3, 32'h10, e3, st);
        checks++;
        if (st !== 1) begin
            errors++;
            $display("FAIL skid_release_stalls got=%0d required=1", st);
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_valid && n < 50);
        checks++;
        if (obs.size() !== 3 || sb.size() !== 3) begin
            errors++;
            $display("FAIL skid_count issued=%0d accepted=%0d required=3", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            g = obs.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL skid_order got=%h required=%h", g, e);
            end
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_reset_full();
        int   st;
        int   n;
        exp_t e;
        exp_t g;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = mk(7'd0, 32'd0, 32'd5, 32'd5, 32'h3000 + 32'(i), 5'd1, 1'b1, 1'b0, 1'b0);
            send(32'h00500093, 32'h3000 + 32'(i), 32'd0, 32'd0, e, st);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstfull_flush out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        sb.delete();
        obs.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstfull_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        e = mk(7'd16, 32'd0, 32'h12345000, 32'h12345000, 32'h3100, 5'd1, 1'b1, 1'b0, 1'b0);
        send(32'h123450B7, 32'h3100, 32'd9, 32'd9, e, st);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_valid && n < 50);
        checks++;
        if (obs.size() !== 1 || sb.size() !== 1) begin
            errors++;
            $display("FAIL rstfull_count issued=%0d accepted=%0d required=1", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            g = obs.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rstfull_issue got=%h required=%h", g, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
